klt_track_sequencer: RTL
========================

Name: klt_track_sequencer

Overview:
- Per-frame controller for the KLT tracking datapath.
- Gates ROI accumulation and waits for roi_end, then for the linear-solver result.
- Applies the bounded integer displacement to the tracked point and publishes point_x0/point_y0 to the ROI check and overlay box.
- Detects lost tracks (repeated missing solutions) and handles re-arm and reset of the point at frame boundaries.

Parameters:
H_ACTIVE, 800, active pixels per line; x bound
V_ACTIVE, 600, active lines per frame; y bound
INIT_X, 400, point x after reset/reset_position
INIT_Y, 300, point y after reset/reset_position
MARGIN, 10, minimum distance of point from any frame edge (half box width)
MAX_STEP, 8, saturation magnitude of per-frame displacement per axis
MISS_LIMIT, 3, consecutive frames without a solution before track_lost
DEADBAND, 1, jitter threshold; used only with KLT_DEADBAND_EN

Ports:
rx_pclk  in  1  pixel clock
rx_rstn  in  1  asynchronous active-low reset
enable_tracking  in  1  level; tracking requested
reset_position  in  1  level; sampled at frame boundary
vsync_in  in  1  context-aligned vsync; rising edge = frame boundary
roi_end  in  1  pulse; last ROI pixel accumulated
dx_valid  in  1  pulse; solver output valid
dx_int  in  12  signed integer x displacement
dy_int  in  11  signed integer y displacement
tracking_active  out  1  enables ROI accumulation this frame
point_x0  out  12  tracked point x
point_y0  out  11  tracked point y
update_strobe  out  1  one-cycle pulse; point updated
track_lost  out  1  sticky lost flag
frame_count  out  16  successful updates, wraps at 65535->0

Behaviour:
- Reset values: state IDLE, tracking_active 0, point = (INIT_X, INIT_Y), update_strobe 0, track_lost 0, frame_count 0, miss counter 0.
- vs_rise = vsync_in & ~vsync_d (one register stage); all frame-boundary decisions use vs_rise.
- States: IDLE, ARM, ACCUM, SOLVE, UPDATE, WAIT_VS.
- IDLE: tracking_active 0. On vs_rise with enable_tracking=1 and track_lost=0 -> ARM.
- ARM: template frame.
  - tracking_active 1.
  - roi_end and dx_valid are ignored.
  - On vs_rise -> ACCUM.
- ACCUM: tracking_active 1.
  - roi_end -> SOLVE.
  - vs_rise first -> miss++, stay ACCUM.
- SOLVE:
  - dx_valid -> UPDATE.
  - vs_rise first -> miss++, -> ACCUM.
  - dx_valid and vs_rise in the same cycle: vs_rise wins; the result is discarded and counted as a miss.
- UPDATE: exactly 1 cycle, entered the cycle after dx_valid.
  - step = saturate(d, ±MAX_STEP).
  - Point = clamp(point + step, MARGIN .. H_ACTIVE-1-MARGIN) for x; y uses the same rule with V_ACTIVE.
  - Point registers and update_strobe=1 on the same edge; frame_count++; miss=0.
  - -> WAIT_VS.
- WAIT_VS: tracking_active 1; roi_end and dx_valid ignored; vs_rise -> ACCUM.
- Arithmetic: dx_int and dy_int are sign-extended to 13 bits before the add; the clamp operates on the signed sum, so no wrap-around.
- Miss reaching MISS_LIMIT (checked at increment): track_lost=1, -> IDLE, point held.
- Priority at vs_rise, highest first:
  1. reset_position=1: point=(INIT_X, INIT_Y), track_lost=0, miss=0, -> ARM if enable_tracking else IDLE.
  2. enable_tracking=0: -> IDLE, point held.
  3. Normal transitions.
- tracking_active is a registered output of the state; it changes one cycle after vs_rise is detected.
- Asynchronous reset mid-frame returns all registers to reset values immediately.
- A roi_end or dx_valid outside the consuming state has no effect.

Optional Feature:
- Macro: KLT_DEADBAND_EN.
- Defined: in UPDATE, an axis with |d| <= DEADBAND contributes step 0. The update still occurs, with strobe, count and miss reset.
- Undefined: DEADBAND parameter unused; raw saturated step applied.

Decomposition:
- Package klt_pkg:
  - State enum.
  - Width constants X_W=12, Y_W=11, CNT_W=16.
  - Signed sum width SUM_W=13.
- Sub-module klt_step_clamp (parameterised width, MAX_STEP, LO, HI): saturate step, add, bound. Instantiated once per axis.
- FSM and counters stay in the top.

Test Plan:
1. Reset, enable=1, run 3 frames, each with roi_end and dx_valid, dx=3, dy=-2 -> ARM frame gives no update. Then x 400->403->406, y 300->298->296, two update_strobe pulses, frame_count=2.
2. dx=50, dy=-40 with point (400,300) -> saturated to (408,292). Then with point at x=785 and dx=8 -> x clamps to 789 (800-1-10).
3. Three consecutive frames with no dx_valid after ARM -> track_lost=1 after the 3rd vs_rise, state IDLE, tracking_active 0, point unchanged.
4. track_lost=1, reset_position=1 at vs_rise with enable=1 -> point (400,300), track_lost=0, ARM.
5. dx_valid coincident with vs_rise in SOLVE -> no update_strobe, miss=1, point unchanged.
6. With KLT_DEADBAND_EN, DEADBAND=1, dx=1, dy=-1 -> point unchanged, update_strobe pulses, frame_count++. Without the macro -> (401,299).

Source files
------------

// File: rtl/klt_pkg.sv
// -----------------------------------------------------------------------------
// klt_pkg
// Shared types and widths for the KLT track sequencer slice.
//   klt_state_e : per-frame sequencer states
//   X_W / Y_W   : tracked point widths (x / y)
//   CNT_W       : successful-update frame counter width
//   SUM_W       : signed width used for point + displacement before clamping
// -----------------------------------------------------------------------------
package klt_pkg;

  localparam int X_W   = 12;
  localparam int Y_W   = 11;
  localparam int CNT_W = 16;
  localparam int SUM_W = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    ACCUM   = 3'd2,
    SOLVE   = 3'd3,
    UPDATE  = 3'd4,
    WAIT_VS = 3'd5
  } klt_state_e;

endpackage

// File: rtl/klt_step_clamp.sv
// -----------------------------------------------------------------------------
// klt_step_clamp
// Applies one axis of the per-frame displacement to the tracked point:
// saturates the raw displacement to +/-MAX_STEP, adds it to the current
// position in a signed SUM_W domain and bounds the result to [LO, HI].
// Purely combinational; one instance per axis.
//
// Optional feature (macro KLT_DEADBAND_EN): when defined, a displacement with
// |d| <= DEADBAND contributes a zero step, suppressing sub-pixel jitter.
//
// Ports:
//   point_in  : current position (unsigned, W bits)
//   d         : raw signed displacement from the solver (W bits)
//   point_out : bounded next position (unsigned, W bits)
// -----------------------------------------------------------------------------
module klt_step_clamp
  import klt_pkg::*;
#(
  parameter int W        = 12,
  parameter int MAX_STEP = 8,
  parameter int LO       = 10,
  parameter int HI       = 789,
  parameter int DEADBAND = 1
) (
  input  logic [W-1:0]        point_in,
  input  logic signed [W-1:0] d,
  output logic [W-1:0]        point_out
);

  localparam logic signed [SUM_W-1:0] STEP_MAX = SUM_W'(MAX_STEP);
  localparam logic signed [SUM_W-1:0] POS_LO   = SUM_W'(LO);
  localparam logic signed [SUM_W-1:0] POS_HI   = SUM_W'(HI);
  localparam logic signed [SUM_W-1:0] DB_TH    = SUM_W'(DEADBAND);
`ifdef KLT_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // Bound the per-frame step; the deadband test uses the raw value.
  function automatic logic signed [SUM_W-1:0] sat_step(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] r;
    if (v > STEP_MAX)       r = STEP_MAX;
    else if (v < -STEP_MAX) r = -STEP_MAX;
    else                    r = v;
    if (DB_EN && (v <= DB_TH) && (v >= -DB_TH)) r = '0;
    return r;
  endfunction

  // Keep the point MARGIN away from every frame edge.
  function automatic logic signed [SUM_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] r;
    if (v < POS_LO)      r = POS_LO;
    else if (v > POS_HI) r = POS_HI;
    else                 r = v;
    return r;
  endfunction

  logic signed [SUM_W-1:0] d_ext;
  logic signed [SUM_W-1:0] pos_ext;
  logic signed [SUM_W-1:0] sum;

  assign d_ext     = SUM_W'(d);
  assign pos_ext   = signed'(SUM_W'(point_in));
  assign sum       = pos_ext + sat_step(d_ext);
  assign point_out = W'(clamp_pos(sum));

endmodule

// File: rtl/klt_track_sequencer.sv
// -----------------------------------------------------------------------------
// klt_track_sequencer
// Per-frame controller for the KLT tracking datapath. Arms on a frame
// boundary, gates ROI accumulation, waits for roi_end and then the solver
// result, applies the bounded displacement to the tracked point and flags a
// lost track after MISS_LIMIT consecutive frames without a solution.
// Build option: KLT_DEADBAND_EN (jitter deadband, see klt_step_clamp).
//
// Ports:
//   rx_pclk, rx_rstn   : pixel clock, asynchronous active-low reset
//   enable_tracking    : level, tracking requested
//   reset_position     : level, sampled at frame boundary
//   vsync_in           : rising edge marks a frame boundary
//   roi_end            : pulse, ROI accumulation finished
//   dx_valid           : pulse, dx_int/dy_int valid
//   dx_int, dy_int     : signed integer displacement
//   tracking_active    : ROI accumulation enable (registered)
//   point_x0, point_y0 : tracked point
//   update_strobe      : one-cycle pulse with each point update
//   track_lost         : sticky lost flag
//   frame_count        : count of successful updates (wraps)
// -----------------------------------------------------------------------------
module klt_track_sequencer
  import klt_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int INIT_X     = 400,
  parameter int INIT_Y     = 300,
  parameter int MARGIN     = 10,
  parameter int MAX_STEP   = 8,
  parameter int MISS_LIMIT = 3,
  parameter int DEADBAND   = 1
) (
  input  logic              rx_pclk,
  input  logic              rx_rstn,
  input  logic              enable_tracking,
  input  logic              reset_position,
  input  logic              vsync_in,
  input  logic              roi_end,
  input  logic              dx_valid,
  input  logic [X_W-1:0]    dx_int,
  input  logic [Y_W-1:0]    dy_int,
  output logic              tracking_active,
  output logic [X_W-1:0]    point_x0,
  output logic [Y_W-1:0]    point_y0,
  output logic              update_strobe,
  output logic              track_lost,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  klt_state_e              state;
  klt_state_e              state_next;
  logic                    vsync_d;
  logic                    vs_rise;
  logic [MISS_W-1:0]       miss_cnt;
  logic signed [X_W-1:0]   dx_p0;
  logic signed [Y_W-1:0]   dy_p0;
  logic [X_W-1:0]          x_next;
  logic [Y_W-1:0]          y_next;
  logic                    pos_reset;
  logic                    frame_ovr;
  logic                    miss_event;
  logic                    lost_event;
  logic                    accept_dx;
  logic                    update_ok;

  assign vs_rise    = vsync_in & ~vsync_d;
  assign pos_reset  = vs_rise & reset_position;
  // Frame-boundary overrides (reset_position, tracking disabled) pre-empt
  // every normal transition, including a pending update.
  assign frame_ovr  = vs_rise & (reset_position | ~enable_tracking);
  assign miss_event = vs_rise & ~frame_ovr & ((state == ACCUM) | (state == SOLVE));
  assign lost_event = miss_event & ((int'(miss_cnt) + 1) >= MISS_LIMIT);

  // State register
  always_ff @(posedge rx_pclk or negedge rx_rstn) begin
    if (!rx_rstn) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (pos_reset) begin
      state_next = enable_tracking ? ARM : IDLE;
    end else if (frame_ovr) begin
      state_next = IDLE;
    end else if (lost_event) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (vs_rise && !track_lost) state_next = ARM;
        ARM:     if (vs_rise) state_next = ACCUM;
        ACCUM:   if (!vs_rise && roi_end) state_next = SOLVE;
        // A result arriving with the frame boundary is stale: vs_rise wins.
        SOLVE: begin
          if (vs_rise)       state_next = ACCUM;
          else if (dx_valid) state_next = UPDATE;
        end
        UPDATE:  state_next = vs_rise ? ACCUM : WAIT_VS;
        WAIT_VS: if (vs_rise) state_next = ACCUM;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    accept_dx = (state == SOLVE) & dx_valid & ~vs_rise;
    update_ok = (state == UPDATE) & ~frame_ovr;
  end

  // Stage p0: capture the solver result when it is consumed
  always_ff @(posedge rx_pclk) begin
    if (accept_dx) begin
      dx_p0 <= signed'(dx_int);
      dy_p0 <= signed'(dy_int);
    end
  end

  klt_step_clamp #(
    .W(X_W), .MAX_STEP(MAX_STEP), .LO(MARGIN), .HI(H_ACTIVE - 1 - MARGIN),
    .DEADBAND(DEADBAND)
  ) u_clamp_x (
    .point_in (point_x0),
    .d        (dx_p0),
    .point_out(x_next)
  );

  klt_step_clamp #(
    .W(Y_W), .MAX_STEP(MAX_STEP), .LO(MARGIN), .HI(V_ACTIVE - 1 - MARGIN),
    .DEADBAND(DEADBAND)
  ) u_clamp_y (
    .point_in (point_y0),
    .d        (dy_p0),
    .point_out(y_next)
  );

  // Stage p1: point, strobe, counters and flags
  always_ff @(posedge rx_pclk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      vsync_d         <= 1'b0;
      tracking_active <= 1'b0;
      point_x0        <= X_W'(INIT_X);
      point_y0        <= Y_W'(INIT_Y);
      update_strobe   <= 1'b0;
      track_lost      <= 1'b0;
      frame_count     <= '0;
      miss_cnt        <= '0;
    end else begin
      vsync_d         <= vsync_in;
      tracking_active <= (state_next != IDLE);
      update_strobe   <= update_ok;

      if (pos_reset) begin
        point_x0 <= X_W'(INIT_X);
        point_y0 <= Y_W'(INIT_Y);
      end else if (update_ok) begin
        point_x0 <= x_next;
        point_y0 <= y_next;
      end

      if (update_ok) frame_count <= frame_count + 1'b1;

      if (pos_reset || update_ok) miss_cnt <= '0;
      else if (miss_event)        miss_cnt <= miss_cnt + MISS_W'(1);

      if (pos_reset)       track_lost <= 1'b0;
      else if (lost_event) track_lost <= 1'b1;
    end
  end

endmodule
